// File: rtl/ft_nmr_module_pkg.sv
// Shared types and default constants for the N-modular-redundancy register-file guard.
package ft_pkg;

  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_CORES  = 3;
  localparam int DEF_MAX_RETRY  = 3;
  // The vote result is sized for the largest supported redundancy (TMR).
  localparam int MAX_CORES      = 3;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_HALT,
    ST_SHIFT,
    ST_RESUME,
    ST_FATAL
  } state_t;

  typedef struct packed {
    logic                 agree;
    logic                 majority_valid;
    logic [MAX_CORES-1:0] dissenter_onehot;
  } vote_t;

endpackage

// File: rtl/ft_nmr_module_if.sv
// Bundle of per-core write ports, PC and recovery controls between the cores and the guard.
interface ft_nmr_module_if #(
  parameter int NUM_CORES  = 3,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);

  logic [NUM_CORES-1:0]                 we_i;
  logic [NUM_CORES-1:0][ADDR_WIDTH-1:0] addr_i;
  logic [NUM_CORES-1:0][DATA_WIDTH-1:0] data_i;
  logic [DATA_WIDTH-1:0]                spc_i;
  logic [DATA_WIDTH-1:0]                spc_o;
  logic                                 we_o;
  logic [ADDR_WIDTH-1:0]                addr_o;
  logic [DATA_WIDTH-1:0]                data_o;
  logic                                 halt_o;
  logic                                 shift_o;
  logic                                 resume_o;
  logic [NUM_CORES-1:0]                 fault_core_o;
  logic                                 fatal_o;
  logic [7:0]                           err_cnt_o;

  // Core side: issues writes and PC, obeys recovery controls.
  modport master (
    output we_i, addr_i, data_i, spc_i,
    input  spc_o, we_o, addr_o, data_o, halt_o, shift_o, resume_o,
    input  fault_core_o, fatal_o, err_cnt_o
  );

  // Guard side.
  modport slave (
    input  we_i, addr_i, data_i, spc_i,
    output spc_o, we_o, addr_o, data_o, halt_o, shift_o, resume_o,
    output fault_core_o, fatal_o, err_cnt_o
  );

endinterface

// File: rtl/ft_nmr_module_voter.sv
// Combinational voter: compares per-core {we, addr, data} tuples (addr/data are
// don't-care when we=0) and picks the majority tuple plus the lone dissenter.
module ft_voter
  import ft_pkg::*;
#(
  parameter int NUM_CORES  = DEF_NUM_CORES,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic [NUM_CORES-1:0]                 we,
  input  logic [NUM_CORES-1:0][ADDR_WIDTH-1:0] addr,
  input  logic [NUM_CORES-1:0][DATA_WIDTH-1:0] data,
  output vote_t                                vote,
  output logic                                 maj_we,
  output logic [ADDR_WIDTH-1:0]                maj_addr,
  output logic [DATA_WIDTH-1:0]                maj_data
);

  logic eq01;
  assign eq01 = (we[0] == we[1]) && (!we[0] || (addr[0] == addr[1] && data[0] == data[1]));

  if (NUM_CORES == 2) begin : g_dmr
    // Two cores can only agree or disagree; there is never a majority to correct with.
    always_comb begin
      vote                = '0;
      vote.agree          = eq01;
      vote.majority_valid = eq01;
      maj_we              = we[0];
      maj_addr            = addr[0];
      maj_data            = data[0];
    end
  end else begin : g_tmr
    logic eq02, eq12;
    assign eq02 = (we[0] == we[2]) && (!we[0] || (addr[0] == addr[2] && data[0] == data[2]));
    assign eq12 = (we[1] == we[2]) && (!we[1] || (addr[1] == addr[2] && data[1] == data[2]));

    // Tuple equality is transitive, so at most one pair can match when not all agree.
    always_comb begin
      vote     = '0;
      maj_we   = we[0];
      maj_addr = addr[0];
      maj_data = data[0];
      if (eq01 && eq02) begin
        vote.agree          = 1'b1;
        vote.majority_valid = 1'b1;
      end else if (eq01) begin
        vote.majority_valid   = 1'b1;
        vote.dissenter_onehot = 3'b100;
      end else if (eq02) begin
        vote.majority_valid   = 1'b1;
        vote.dissenter_onehot = 3'b010;
      end else if (eq12) begin
        vote.majority_valid   = 1'b1;
        vote.dissenter_onehot = 3'b001;
        maj_we                = we[1];
        maj_addr              = addr[1];
        maj_data              = data[1];
      end
    end
  end

endmodule

// File: rtl/ft_nmr_module.sv
// Redundant-core register-file guard: votes each cycle's writes, keeps a shadow
// copy of the register file and checkpoint PC, and on disagreement halts the
// cores, streams the shadow file back to them and resumes from the checkpoint.
module ft_nmr_module
  import ft_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_CORES  = DEF_NUM_CORES,
  parameter int MAX_RETRY  = DEF_MAX_RETRY
) (
  input  logic          clk_i,
  input  logic          rst_i,
  ft_nmr_module_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [7:0] RETRY_LAST = 8'(MAX_RETRY - 1);

  state_t                  state_reg, state_next;
  logic [DATA_WIDTH-1:0]   shadow_reg [DEPTH];
  logic [DATA_WIDTH-1:0]   ckpt_reg;
  logic [7:0]              retry_reg;
  logic [7:0]              err_cnt_reg;
  logic [NUM_CORES-1:0]    fault_reg;
  logic [ADDR_WIDTH-1:0]   shift_idx_reg;
  logic                    we_o_reg, we_o_next;
  logic [ADDR_WIDTH-1:0]   addr_o_reg, addr_o_next;
  logic [DATA_WIDTH-1:0]   data_o_reg, data_o_next;

  vote_t                   vote;
  logic                    maj_we;
  logic [ADDR_WIDTH-1:0]   maj_addr;
  logic [DATA_WIDTH-1:0]   maj_data;

  ft_voter #(
    .NUM_CORES (NUM_CORES),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_voter (
    .we      (bus.we_i),
    .addr    (bus.addr_i),
    .data    (bus.data_i),
    .vote    (vote),
    .maj_we  (maj_we),
    .maj_addr(maj_addr),
    .maj_data(maj_data)
  );

  logic                  run_st;
  logic                  commit_we;
  logic                  correct_ev;
  logic                  retry_exhausted;
  logic [ADDR_WIDTH-1:0] idx_inc;

  assign run_st          = (state_reg == ST_RUN);
  assign commit_we       = run_st && vote.majority_valid && maj_we;
  assign correct_ev      = run_st && (|vote.dissenter_onehot);
  assign retry_exhausted = (retry_reg >= RETRY_LAST);
  assign idx_inc         = shift_idx_reg + ADDR_WIDTH'(1);

  // Recovery sequencing: one HALT cycle, DEPTH restore cycles, one RESUME cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RUN: begin
        if (!vote.agree) begin
          if (vote.majority_valid || !retry_exhausted) state_next = ST_HALT;
          else                                         state_next = ST_FATAL;
        end
      end
      ST_HALT:   state_next = ST_SHIFT;
      ST_SHIFT:  if (&shift_idx_reg) state_next = ST_RESUME;
      ST_RESUME: state_next = ST_RUN;
      ST_FATAL:  state_next = ST_FATAL;
      default:   state_next = ST_RUN;
    endcase
  end

  // Write-port source: voted commits in RUN, then the restore stream which is
  // prefetched one cycle ahead so entry k is on the port during SHIFT cycle k.
  always_comb begin
    we_o_next   = 1'b0;
    addr_o_next = '0;
    data_o_next = '0;
    case (state_reg)
      ST_RUN: begin
        if (vote.majority_valid && maj_we) begin
          we_o_next   = 1'b1;
          addr_o_next = maj_addr;
          data_o_next = maj_data;
        end
      end
      ST_HALT: begin
        we_o_next   = 1'b1;
        data_o_next = shadow_reg[0];
      end
      ST_SHIFT: begin
        if (!(&shift_idx_reg)) begin
          we_o_next   = 1'b1;
          addr_o_next = idx_inc;
          data_o_next = shadow_reg[idx_inc];
        end
      end
      default: ;
    endcase
  end

  // State, restore index and registered write port.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg     <= ST_RUN;
      shift_idx_reg <= '0;
      we_o_reg      <= 1'b0;
      addr_o_reg    <= '0;
      data_o_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      we_o_reg   <= we_o_next;
      addr_o_reg <= addr_o_next;
      data_o_reg <= data_o_next;
      if (state_reg == ST_SHIFT) shift_idx_reg <= idx_inc;
    end
  end

  // Shadow register file follows every voted write.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) shadow_reg[i] <= '0;
    end else if (commit_we) begin
      shadow_reg[maj_addr] <= maj_data;
    end
  end

  // Checkpoint PC, retry budget, fault attribution and recovery counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ckpt_reg    <= '0;
      retry_reg   <= '0;
      err_cnt_reg <= '0;
      fault_reg   <= '0;
    end else if (run_st) begin
      // A corrected cycle is not a clean point to restart from, so only full agreement moves it.
      if (vote.agree) ckpt_reg <= bus.spc_i;
      if (vote.majority_valid && maj_we) retry_reg <= '0;
      else if (!vote.majority_valid)     retry_reg <= retry_reg + 8'd1;
      if (correct_ev) fault_reg <= vote.dissenter_onehot[NUM_CORES-1:0];
      if (state_next == ST_HALT && err_cnt_reg != 8'hFF) err_cnt_reg <= err_cnt_reg + 8'd1;
    end
  end

  assign bus.spc_o        = ckpt_reg;
  assign bus.we_o         = we_o_reg;
  assign bus.addr_o       = addr_o_reg;
  assign bus.data_o       = data_o_reg;
  assign bus.halt_o       = (state_reg == ST_HALT) || (state_reg == ST_SHIFT) || (state_reg == ST_FATAL);
  assign bus.shift_o      = (state_reg == ST_SHIFT);
  assign bus.resume_o     = (state_reg == ST_RESUME);
  assign bus.fatal_o      = (state_reg == ST_FATAL);
  assign bus.fault_core_o = fault_reg;
  assign bus.err_cnt_o    = err_cnt_reg;

endmodule

// File: tb/tb_ft_nmr_module.sv
// Bench for the redundancy guard: a TMR and a DMR instance run side by side,
// each against a cycle-level reference model built from tuple match counts.
module tb_ft_nmr_module;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;
  localparam int MAXR  = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ft_nmr_module_if #(.NUM_CORES(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if_t ();
  ft_nmr_module_if #(.NUM_CORES(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if_d ();

  ft_nmr_module #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CORES(3), .MAX_RETRY(MAXR))
    dut_t (.clk_i(clk), .rst_i(rst), .bus(if_t));
  ft_nmr_module #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CORES(2), .MAX_RETRY(MAXR))
    dut_d (.clk_i(clk), .rst_i(rst), .bus(if_d));

  // Stimulus per instance (0 = TMR, 1 = DMR) and per core.
  logic          s_we   [2][3];
  logic [AW-1:0] s_addr [2][3];
  logic [DW-1:0] s_data [2][3];
  logic [DW-1:0] s_spc  [2];

  always_comb begin
    for (int c = 0; c < 3; c++) begin
      if_t.we_i[c]   = s_we[0][c];
      if_t.addr_i[c] = s_addr[0][c];
      if_t.data_i[c] = s_data[0][c];
    end
    for (int c = 0; c < 2; c++) begin
      if_d.we_i[c]   = s_we[1][c];
      if_d.addr_i[c] = s_addr[1][c];
      if_d.data_i[c] = s_data[1][c];
    end
    if_t.spc_i = s_spc[0];
    if_d.spc_i = s_spc[1];
  end

  // Observed outputs gathered per instance; ctrl = {halt, shift, resume, fatal}.
  logic [3:0]    o_ctrl  [2];
  logic          o_we    [2];
  logic [AW-1:0] o_addr  [2];
  logic [DW-1:0] o_data  [2];
  logic [DW-1:0] o_spc   [2];
  logic [2:0]    o_fault [2];
  logic [7:0]    o_err   [2];

  always_comb begin
    o_ctrl[0]  = {if_t.halt_o, if_t.shift_o, if_t.resume_o, if_t.fatal_o};
    o_we[0]    = if_t.we_o;
    o_addr[0]  = if_t.addr_o;
    o_data[0]  = if_t.data_o;
    o_spc[0]   = if_t.spc_o;
    o_fault[0] = if_t.fault_core_o;
    o_err[0]   = if_t.err_cnt_o;
    o_ctrl[1]  = {if_d.halt_o, if_d.shift_o, if_d.resume_o, if_d.fatal_o};
    o_we[1]    = if_d.we_o;
    o_addr[1]  = if_d.addr_o;
    o_data[1]  = if_d.data_o;
    o_spc[1]   = if_d.spc_o;
    o_fault[1] = {1'b0, if_d.fault_core_o};
    o_err[1]   = if_d.err_cnt_o;
  end

  // Reference model. m_rec: -1 running, 0 halt cycle, 1..DEPTH restore entry m_rec-1, DEPTH+1 resume.
  logic [DW-1:0] m_shadow [2][DEPTH];
  logic [DW-1:0] m_ckpt   [2];
  int            m_retry  [2];
  int            m_err    [2];
  logic [2:0]    m_fault  [2];
  bit            m_fatal  [2];
  int            m_rec    [2];
  bit            m_we     [2];
  logic [AW-1:0] m_addr   [2];
  logic [DW-1:0] m_data   [2];

  int    ncores [2] = '{3, 2};
  string nm     [2] = '{"tmr", "dmr"};
  int    errors = 0;
  int    checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < DEPTH; i++) m_shadow[u][i] = '0;
      m_ckpt[u] = '0; m_retry[u] = 0; m_err[u] = 0; m_fault[u] = '0;
      m_fatal[u] = 0; m_rec[u] = -1; m_we[u] = 0; m_addr[u] = '0; m_data[u] = '0;
    end
  endtask

  function automatic logic [AW+DW:0] key_of(input int u, input int c);
    return s_we[u][c] ? {1'b1, s_addr[u][c], s_data[u][c]} : '0;
  endfunction

  task automatic model_commit(input int u, input int c);
    m_we[u] = s_we[u][c];
    if (s_we[u][c]) begin
      m_shadow[u][s_addr[u][c]] = s_data[u][c];
      m_addr[u]  = s_addr[u][c];
      m_data[u]  = s_data[u][c];
      m_retry[u] = 0;
    end
  endtask

  task automatic model_step(input int u);
    int n, best, bi;
    int cnt [3];
    n = ncores[u];
    if (m_fatal[u]) begin
      m_we[u] = 0;
    end else if (m_rec[u] >= 0) begin
      m_we[u] = 0;
      m_rec[u]++;
      if (m_rec[u] > DEPTH + 1) m_rec[u] = -1;
    end else begin
      best = 0; bi = 0;
      for (int c = 0; c < n; c++) begin
        cnt[c] = 0;
        for (int d = 0; d < n; d++) if (key_of(u, c) == key_of(u, d)) cnt[c]++;
        if (cnt[c] > best) begin best = cnt[c]; bi = c; end
      end
      if (best == n) begin
        m_ckpt[u] = s_spc[u];
        model_commit(u, bi);
      end else if (best == 2) begin
        model_commit(u, bi);
        m_fault[u] = '0;
        for (int c = 0; c < n; c++) if (cnt[c] == 1) m_fault[u][c] = 1'b1;
        m_rec[u] = 0;
        if (m_err[u] < 255) m_err[u]++;
      end else begin
        m_we[u] = 0;
        m_retry[u]++;
        if (m_retry[u] >= MAXR) m_fatal[u] = 1;
        else begin
          m_rec[u] = 0;
          if (m_err[u] < 255) m_err[u]++;
        end
      end
    end
  endtask

  task automatic check_outputs(input int u);
    logic [3:0] ec; logic ew; logic [AW-1:0] ea; logic [DW-1:0] ed; int r;
    r = m_rec[u];
    ew = 0; ea = '0; ed = '0;
    if (m_fatal[u]) ec = 4'b1001;
    else if (r < 0)  begin ec = 4'b0000; ew = m_we[u]; ea = m_addr[u]; ed = m_data[u]; end
    else if (r == 0) begin ec = 4'b1000; ew = m_we[u]; ea = m_addr[u]; ed = m_data[u]; end
    else if (r <= DEPTH) begin ec = 4'b1100; ew = 1; ea = AW'(r - 1); ed = m_shadow[u][r-1]; end
    else ec = 4'b0010;
    check({nm[u], " ctrl"}, 64'(o_ctrl[u]), 64'(ec));
    check({nm[u], " we_o"}, 64'(o_we[u]), 64'(ew));
    if (ew) begin
      check({nm[u], " addr_o"}, 64'(o_addr[u]), 64'(ea));
      check({nm[u], " data_o"}, 64'(o_data[u]), 64'(ed));
    end
    check({nm[u], " spc_o"}, 64'(o_spc[u]), 64'(m_ckpt[u]));
    check({nm[u], " fault"}, 64'(o_fault[u]), 64'(m_fault[u]));
    check({nm[u], " err_cnt"}, 64'(o_err[u]), 64'(m_err[u]));
  endtask

  // Inputs are already set at a falling edge; advance one rising edge and compare.
  task automatic tick();
    model_step(0);
    model_step(1);
    @(negedge clk);
    check_outputs(0);
    check_outputs(1);
  endtask

  task automatic set_all(input int u, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    for (int c = 0; c < 3; c++) begin s_we[u][c] = we; s_addr[u][c] = a; s_data[u][c] = d; end
  endtask

  task automatic rand_stim(input int u);
    int r, n, d; logic bw; logic [AW-1:0] ba; logic [DW-1:0] bd;
    n  = ncores[u];
    r  = $urandom_range(0, 99);
    bw = ($urandom_range(0, 4) != 0) || (r >= 85);
    ba = AW'($urandom);
    bd = $urandom;
    for (int c = 0; c < 3; c++) begin
      s_we[u][c]   = bw;
      s_addr[u][c] = bw ? ba : AW'($urandom);
      s_data[u][c] = bw ? bd : $urandom;
    end
    if (r >= 70 && r < 85 && n == 3) begin
      d = $urandom_range(0, 2);
      if (!bw) s_we[u][d] = 1'b1;
      else if ($urandom_range(0, 1) == 0) s_we[u][d] = 1'b0;
      else s_data[u][d] = bd ^ (32'h1 << $urandom_range(0, 31));
    end else if (r >= 85) begin
      s_data[u][1] = bd ^ 32'h1;
      if (n == 3) s_data[u][2] = bd ^ 32'h2;
    end
    s_spc[u] = $urandom;
  endtask

  task automatic idle_until_run(input int u);
    for (int k = 0; k < 60 && m_rec[u] >= 0; k++) begin
      set_all(0, 1'b0, '0, '0);
      set_all(1, 1'b0, '0, '0);
      tick();
    end
    check({nm[u], " back in run"}, 64'(o_ctrl[u]), 64'd0);
  endtask

  int halt_cnt, resume_cnt;

  initial begin
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin set_all(u, 1'b0, '0, '0); s_spc[u] = '0; end
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs(0);
    check_outputs(1);
    rst = 1'b0;

    // Agreeing writes on both instances.
    for (int i = 0; i < 32; i++) begin
      for (int u = 0; u < 2; u++) begin set_all(u, 1'b1, AW'(i), DW'(i * 10)); s_spc[u] = 32'h80; end
      tick();
    end
    set_all(0, 1'b0, '0, '0);
    set_all(1, 1'b0, '0, '0);
    tick();
    check("tmr spc after writes", 64'(if_t.spc_o), 64'h80);

    // TMR single dissenter on core 1.
    set_all(0, 1'b1, AW'(10), DW'(100));
    s_data[0][1] = DW'(99);
    halt_cnt = 0; resume_cnt = 0;
    tick();
    for (int k = 0; k < 40; k++) begin
      if (if_t.halt_o) halt_cnt++;
      if (if_t.resume_o) resume_cnt++;
      set_all(0, 1'b0, '0, '0);
      tick();
    end
    check("tmr halt cycles", 64'(halt_cnt), 64'd33);
    check("tmr resume cycles", 64'(resume_cnt), 64'd1);
    check("tmr fault core", 64'(if_t.fault_core_o), 64'b010);
    check("tmr err_cnt", 64'(if_t.err_cnt_o), 64'd1);

    // DMR no-majority: core 0 writes, core 1 does not.
    set_all(1, 1'b0, '0, '0);
    s_we[1][0] = 1'b1; s_addr[1][0] = AW'(10); s_data[1][0] = DW'(100);
    s_spc[1] = 32'h1234;
    tick();
    idle_until_run(1);
    check("dmr spc held", 64'(if_d.spc_o), 64'h80);

    // DMR: clear retry with a good write, then three no-majority events.
    set_all(1, 1'b1, AW'(1), DW'(7));
    tick();
    for (int e = 0; e < 3; e++) begin
      set_all(1, 1'b1, AW'(2), DW'(5));
      s_data[1][1] = DW'(6);
      tick();
      if (e < 2) begin
        check("dmr not yet fatal", 64'(if_d.fatal_o), 64'd0);
        idle_until_run(1);
      end
    end
    check("dmr fatal", 64'(if_d.fatal_o), 64'd1);
    for (int k = 0; k < 5; k++) begin rand_stim(1); tick(); end
    check("dmr halt stuck", 64'(if_d.halt_o), 64'd1);

    // Reset in the middle of a TMR restore.
    set_all(0, 1'b1, AW'(4), DW'(44));
    s_we[0][2] = 1'b0;
    tick();
    for (int k = 0; k < 10 && m_rec[0] != 6; k++) begin rand_stim(0); tick(); end
    check("tmr shift k5 addr", 64'(if_t.addr_o), 64'd5);
    rst = 1'b1;
    #1;
    check("rst tmr ctrl", 64'({if_t.halt_o, if_t.shift_o, if_t.resume_o, if_t.fatal_o, if_t.we_o}), 64'd0);
    check("rst tmr addr/data", 64'({if_t.addr_o, if_t.data_o}), 64'd0);
    check("rst tmr spc/fault/err", 64'({if_t.spc_o, if_t.fault_core_o, if_t.err_cnt_o}), 64'd0);
    check("rst dmr ctrl", 64'(o_ctrl[1]), 64'd0);
    model_reset();
    @(negedge clk);
    check_outputs(0);
    check_outputs(1);
    rst = 1'b0;
    for (int u = 0; u < 2; u++) begin set_all(u, 1'b1, AW'(3), DW'(32'h33)); s_spc[u] = 32'h44; end
    tick();
    check("post-reset commit", 64'({if_t.we_o, if_t.addr_o, if_t.data_o}), {31'd0, 1'b1, 5'd3, 32'h33});

    // Randomised traffic, including garbage while recovering.
    for (int k = 0; k < 1200; k++) begin
      rand_stim(0);
      rand_stim(1);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ft_nmr_module.md
FT_NMR_MODULE -- requirements
Module: ft_nmr_module

Interface
REQ-001 Parameter ADDR_WIDTH, default 5, register-file index width; DEPTH = 2**ADDR_WIDTH.
REQ-002 Parameter DATA_WIDTH, default 32, register data and PC width.
REQ-003 Parameter NUM_CORES, default 3, legal values 2 (DMR) or 3 (TMR).
REQ-004 Parameter MAX_RETRY, default 3, uncorrectable recoveries tolerated before fatal.
REQ-005 clk_i  in  1  single clock, rising edge.
REQ-006 rst_i  in  1  asynchronous, active-high reset.
REQ-007 we_i  in  NUM_CORES  per-core register-file write enable.
REQ-008 addr_i  in  NUM_CORES x ADDR_WIDTH  per-core write address.
REQ-009 data_i  in  NUM_CORES x DATA_WIDTH  per-core write data.
REQ-010 spc_i  in  DATA_WIDTH  current PC from the cores.
REQ-011 spc_o  out  DATA_WIDTH  checkpoint PC, restart address on resume.
REQ-012 we_o, addr_o, data_o  out  1/ADDR_WIDTH/DATA_WIDTH  committed write in RUN; restore stream in SHIFT.
REQ-013 halt_o, shift_o, resume_o  out  1 each  recovery control to cores.
REQ-014 fault_core_o  out  NUM_CORES  one-hot of the minority core from the last TMR correction.
REQ-015 fatal_o  out  1  unrecoverable; sticky until reset.
REQ-016 err_cnt_o  out  8  saturating count of recovery entries.

Function
REQ-017 Per-core tuple = {we, addr, data}; addr and data are ignored when that core's we=0; two tuples agree when equal under this rule.
REQ-018 Inputs are sampled on each rising edge in RUN only; in all other states they are ignored and never committed.
REQ-019 Full agreement: shadow[addr] <= data if we; checkpoint PC <= spc_i; we_o/addr_o/data_o registered, one-cycle latency; retry counter cleared when we=1.
REQ-020 TMR with exactly one dissenting core: majority tuple committed as REQ-019 except checkpoint PC is not updated; fault_core_o <= dissenter; next state HALT.
REQ-021 No majority (any DMR disagreement, or TMR all three distinct): nothing committed; retry counter increments; next state HALT, or FATAL if the counter would reach MAX_RETRY.
REQ-022 FSM states RUN, HALT, SHIFT, RESUME, FATAL; RUN->HALT per REQ-020/021; HALT->SHIFT after 1 cycle; SHIFT->RESUME after DEPTH cycles; RESUME->RUN after 1 cycle; FATAL only exits on reset.
REQ-023 halt_o=1 in HALT, SHIFT, FATAL; shift_o=1 in SHIFT only; resume_o=1 in RESUME only; fatal_o=1 in FATAL.
REQ-024 SHIFT cycle k (0..DEPTH-1): addr_o=k, data_o=shadow[k], we_o=1; the index wraps to 0 and SHIFT is left after k=DEPTH-1.
REQ-025 spc_o continuously drives the checkpoint PC register.
REQ-026 err_cnt_o increments on every RUN->HALT transition and saturates at 255.
REQ-027 Simultaneous all-we=0 on every core counts as agreement, with no commit and checkpoint PC updated.

Reset
REQ-028 rst_i asynchronously forces: state RUN, all shadow entries 0, checkpoint PC 0, retry counter 0, err_cnt_o 0, fault_core_o 0, all outputs 0.
REQ-029 Reset asserted in any state, including mid-SHIFT or FATAL, aborts immediately; the first sample after release is taken in RUN.

Structure
REQ-030 Package ft_pkg holds the state enum, the vote-result typedef {agree, majority_valid, dissenter_onehot} and the default parameter constants.
REQ-031 Sub-module ft_voter (combinational, NUM_CORES-parametrised) produces the vote result and the majority tuple; ft_nmr_module holds the FSM, shadow file, counters and output registers.

Verification
REQ-032 TMR: 32 agreeing writes addr i, data i*10, spc_i=0x80 -> we_o/addr_o/data_o follow 1 cycle later; halt_o stays 0; spc_o=0x80.
REQ-033 TMR: cores 0 and 2 write addr 10 data 100, core 1 writes data 99 -> shadow[10]=100, fault_core_o=3'b010, halt_o for 33 cycles, SHIFT shows addr 10 data 100, resume_o one cycle, err_cnt_o=1.
REQ-034 DMR: core 0 we=1 addr 10 data 100, core 1 we=0 -> no commit, shadow[10] unchanged, full HALT/SHIFT/RESUME, spc_o holds last agreed PC.
REQ-035 DMR with MAX_RETRY=3: three consecutive no-majority events with no agreeing write between them -> fatal_o=1 and halt_o stuck at 1 until reset.
REQ-036 Assert rst_i at SHIFT cycle 5 -> all outputs 0 without a clock edge; after release, an agreeing write commits normally.
